// File: rtl/menu_pkg.sv
// Shared types and constants for the menu controller: FSM states, key indices
// and default timing values.
package menu_pkg;

  typedef enum logic {
    SELECT = 1'b0,
    ACTIVE = 1'b1
  } menu_state_e;

  localparam int unsigned KEY_BACK  = 0;
  localparam int unsigned KEY_NEXT  = 1;
  localparam int unsigned KEY_ENTER = 2;

  localparam int unsigned DEB_CYC_DEF   = 1_000_000;
  localparam int unsigned LONG_CYC_DEF  = 50_000_000;
  localparam int unsigned BLINK_BIT_DEF = 24;
  localparam int unsigned BLINK_W       = 26;

endpackage

// File: rtl/key_event.sv
// Per-key synchroniser, debouncer and short/long press classifier.
// Emits one-cycle short_p on release and one-cycle long_p while still held.
module key_event #(
  parameter int unsigned DEB_CYC  = 4,
  parameter int unsigned LONG_CYC = 100
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic short_p,
  output logic long_p
);

  localparam int unsigned DebW  = $clog2(DEB_CYC + 1);
  localparam int unsigned HoldW = $clog2(LONG_CYC + 1);

  logic             sync1_q, sync2_q;
  logic             armed_q, armed_d;
  logic             level_q, level_d;
  logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             short_q, short_d;
  logic             long_q, long_d;

  always_comb begin
    // Presses only count once the key has been seen released after reset.
    armed_d   = armed_q | ~sync2_q;
    level_d   = level_q;
    deb_cnt_d = '0;
    if (sync2_q != level_q) begin
      if (deb_cnt_q == DebW'(DEB_CYC - 1)) begin
        if (!sync2_q || armed_q) begin
          level_d = sync2_q;
        end
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end

    hold_d = '0;
    if (level_q) begin
      hold_d = (hold_q == HoldW'(LONG_CYC)) ? hold_q : hold_q + 1'b1;
    end

    long_d  = level_q && level_d && (hold_q == HoldW'(LONG_CYC - 1));
    short_d = level_q && !level_d && (hold_q < HoldW'(LONG_CYC));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // Sync flops reset to "pressed" so a held key cannot arm the debouncer.
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      armed_q   <= 1'b0;
      level_q   <= 1'b0;
      deb_cnt_q <= '0;
      hold_q    <= '0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      sync1_q   <= ~key_ni;
      sync2_q   <= sync1_q;
      armed_q   <= armed_d;
      level_q   <= level_d;
      deb_cnt_q <= deb_cnt_d;
      hold_q    <= hold_d;
      short_q   <= short_d;
      long_q    <= long_d;
    end
  end

  assign short_p = short_q;
  assign long_p  = long_q;

endmodule

// File: rtl/menu_control.sv
// Three-key menu: browse N_FUNC functions in SELECT, run one in ACTIVE with a
// one-hot enable, exit on long BACK or the selected function's done.
module menu_control
  import menu_pkg::*;
#(
  parameter int unsigned N_FUNC    = 4,
  parameter int unsigned SEL_W     = $clog2(N_FUNC),
  parameter int unsigned DEB_CYC   = DEB_CYC_DEF,
  parameter int unsigned LONG_CYC  = LONG_CYC_DEF,
  parameter int unsigned BLINK_BIT = BLINK_BIT_DEF,
  parameter bit          WRAP      = 1'b1
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic [2:0]        keys,
  input  logic [N_FUNC-1:0] done,
  output logic [N_FUNC-1:0] enable,
  output logic [N_FUNC-1:0] leds,
  output logic [SEL_W-1:0]  sel,
  output logic              active
);

  logic [2:0] short_ev, long_ev;
  logic       unused_long;

  for (genvar k = 0; k < 3; k++) begin : g_key
    key_event #(
      .DEB_CYC  (DEB_CYC),
      .LONG_CYC (LONG_CYC)
    ) u_key_event (
      .clk_i   (CLOCK_50),
      .rst_ni  (rst_n),
      .key_ni  (keys[k]),
      .short_p (short_ev[k]),
      .long_p  (long_ev[k])
    );
  end

  // Only BACK has a long-press meaning.
  assign unused_long = ^long_ev[KEY_ENTER:KEY_NEXT];

  menu_state_e         state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d, sel_inc, sel_dec;
  logic [N_FUNC-1:0]   enable_q, enable_d, leds_q, leds_d, sel_onehot;
  logic                active_q, active_d;
  logic [BLINK_W-1:0]  blink_q, blink_d;

  always_comb begin
    sel_onehot = {{(N_FUNC-1){1'b0}}, 1'b1} << sel_q;

    if (sel_q == '0) begin
      sel_dec = WRAP ? SEL_W'(N_FUNC - 1) : sel_q;
    end else begin
      sel_dec = sel_q - 1'b1;
    end
    if (sel_q == SEL_W'(N_FUNC - 1)) begin
      sel_inc = WRAP ? '0 : sel_q;
    end else begin
      sel_inc = sel_q + 1'b1;
    end

    state_d = state_q;
    sel_d   = sel_q;
    unique case (state_q)
      SELECT: begin
        if (short_ev[KEY_BACK] && !short_ev[KEY_NEXT]) begin
          sel_d = sel_dec;
        end else if (short_ev[KEY_NEXT] && !short_ev[KEY_BACK]) begin
          sel_d = sel_inc;
        end else if (short_ev[KEY_ENTER] && !short_ev[KEY_BACK] && !short_ev[KEY_NEXT]) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (long_ev[KEY_BACK] || done[sel_q]) begin
          state_d = SELECT;
        end
      end
      default: state_d = SELECT;
    endcase

    // sel never changes on an edge where state_d is ACTIVE, so sel_onehot is current.
    enable_d = (state_d == ACTIVE) ? sel_onehot : '0;
    active_d = (state_d == ACTIVE);
    leds_d   = ((state_q == ACTIVE) || blink_q[BLINK_BIT]) ? sel_onehot : '0;
    blink_d  = blink_q + 1'b1;
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SELECT;
      sel_q    <= '0;
      enable_q <= '0;
      active_q <= 1'b0;
      leds_q   <= '0;
      blink_q  <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      enable_q <= enable_d;
      active_q <= active_d;
      leds_q   <= leds_d;
      blink_q  <= blink_d;
    end
  end

  assign enable = enable_q;
  assign leds   = leds_q;
  assign sel    = sel_q;
  assign active = active_q;

endmodule

// File: tb/tb_menu_control.sv
// Directed bench for menu_control: a wrapping and a saturating instance share stimulus.
module tb_menu_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] keys;
  logic [3:0] done;
  logic [3:0] enable_w, leds_w, enable_s, leds_s;
  logic [1:0] sel_w, sel_s;
  logic       active_w, active_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  menu_control #(
    .N_FUNC (4), .DEB_CYC (4), .LONG_CYC (100), .BLINK_BIT (3), .WRAP (1'b1)
  ) dut_w (
    .CLOCK_50 (clk), .rst_n (rst_n), .keys (keys), .done (done),
    .enable (enable_w), .leds (leds_w), .sel (sel_w), .active (active_w)
  );

  menu_control #(
    .N_FUNC (4), .DEB_CYC (4), .LONG_CYC (100), .BLINK_BIT (3), .WRAP (1'b0)
  ) dut_s (
    .CLOCK_50 (clk), .rst_n (rst_n), .keys (keys), .done (done),
    .enable (enable_s), .leds (leds_s), .sel (sel_s), .active (active_s)
  );

  typedef struct {
    logic [2:0] mask;
    int         hold;
    logic [1:0] sel_w;
    logic [1:0] sel_s;
    logic       act;
    logic [3:0] en_w;
    logic [3:0] en_s;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic press(input logic [2:0] mask, input int hold);
    keys = ~mask;
    repeat (hold) @(negedge clk);
    keys = 3'b111;
    repeat (20) @(negedge clk);
  endtask

  logic [3:0] ls [40];
  int         first;
  logic       steady;

  initial begin
    // mask, hold, sel_w, sel_s, active, en_w, en_s  (both start at sel=1)
    vecs[0]  = '{3'b001, 20, 2'd0, 2'd0, 1'b0, 4'b0000, 4'b0000};
    vecs[1]  = '{3'b001, 20, 2'd3, 2'd0, 1'b0, 4'b0000, 4'b0000};
    vecs[2]  = '{3'b010, 20, 2'd0, 2'd1, 1'b0, 4'b0000, 4'b0000};
    vecs[3]  = '{3'b010, 20, 2'd1, 2'd2, 1'b0, 4'b0000, 4'b0000};
    vecs[4]  = '{3'b010, 20, 2'd2, 2'd3, 1'b0, 4'b0000, 4'b0000};
    vecs[5]  = '{3'b010, 20, 2'd3, 2'd3, 1'b0, 4'b0000, 4'b0000};
    vecs[6]  = '{3'b010, 20, 2'd0, 2'd3, 1'b0, 4'b0000, 4'b0000};
    vecs[7]  = '{3'b011, 20, 2'd0, 2'd3, 1'b0, 4'b0000, 4'b0000};
    vecs[8]  = '{3'b001,  2, 2'd0, 2'd3, 1'b0, 4'b0000, 4'b0000};
    vecs[9]  = '{3'b010, 20, 2'd1, 2'd3, 1'b0, 4'b0000, 4'b0000};
    vecs[10] = '{3'b010, 20, 2'd2, 2'd3, 1'b0, 4'b0000, 4'b0000};
    vecs[11] = '{3'b100, 20, 2'd2, 2'd3, 1'b1, 4'b0100, 4'b1000};
    vecs[12] = '{3'b010, 20, 2'd2, 2'd3, 1'b1, 4'b0100, 4'b1000};
    vecs[13] = '{3'b001, 20, 2'd2, 2'd3, 1'b1, 4'b0100, 4'b1000};
    vecs[14] = '{3'b100, 20, 2'd2, 2'd3, 1'b1, 4'b0100, 4'b1000};

    keys  = 3'b111;
    done  = 4'b0000;
    rst_n = 1'b0;
    #1;
    check("reset_outputs_w", {sel_w, active_w, enable_w, leds_w}, 32'h0);
    check("reset_outputs_s", {sel_s, active_s, enable_s, leds_s}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Short press on NEXT, then watch the selected LED blink with period 16.
    press(3'b010, 20);
    check("next_short_sel", {sel_w, sel_s}, {2'd1, 2'd1});
    check("next_short_enable", {active_w, enable_w}, 5'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ls[i] = leds_w;
    end
    first = 0;
    for (int i = 1; i < 17; i++) begin
      if (first == 0 && ls[i][1] != ls[i-1][1]) first = i;
    end
    check("blink_edge_found", (first != 0), 1);
    steady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ((ls[i] & 4'b1101) != 4'b0000) steady = 1'b0;
    end
    for (int i = first + 1; i < first + 8; i++) begin
      if (ls[i][1] != ls[first][1]) steady = 1'b0;
    end
    check("blink_hold_8", steady, 1'b1);
    check("blink_toggle_8", (ls[first+8][1] != ls[first+7][1]), 1);

    for (int i = 0; i < 15; i++) begin
      press(vecs[i].mask, vecs[i].hold);
      check($sformatf("vec%0d_wrap", i), {sel_w, active_w, enable_w},
            {vecs[i].sel_w, vecs[i].act, vecs[i].en_w});
      check($sformatf("vec%0d_sat", i), {sel_s, active_s, enable_s},
            {vecs[i].sel_s, vecs[i].act, vecs[i].en_s});
    end

    // ACTIVE: LEDs steady on the running function.
    steady = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (leds_w != 4'b0100) steady = 1'b0;
    end
    check("active_leds_steady", steady, 1'b1);

    // done of a non-selected function is ignored; done[sel] exits.
    done = 4'b0010;
    repeat (5) @(negedge clk);
    check("done_other_ignored", {active_w, active_s}, 2'b11);
    done = 4'b0100;
    repeat (3) @(negedge clk);
    check("done_sel_exit_w", {sel_w, active_w, enable_w}, {2'd2, 1'b0, 4'b0000});
    check("done_other_sat", {active_s, enable_s}, {1'b1, 4'b1000});
    done = 4'b0000;
    repeat (3) @(negedge clk);

    // Re-enter on the wrapping instance, then exit both with a long BACK.
    press(3'b100, 20);
    check("reenter_w", {active_w, enable_w}, {1'b1, 4'b0100});
    keys = 3'b110;
    repeat (90) @(negedge clk);
    check("long_not_yet", {active_w, active_s}, 2'b11);
    repeat (30) @(negedge clk);
    check("long_exit_held", {active_w, enable_w, active_s, enable_s}, 10'b0);
    repeat (30) @(negedge clk);
    keys = 3'b111;
    repeat (20) @(negedge clk);
    check("long_no_short_w", {sel_w, active_w}, {2'd2, 1'b0});
    check("long_no_short_s", {sel_s, active_s}, {2'd3, 1'b0});

    // Reset mid-ACTIVE and mid-hold.
    press(3'b100, 20);
    check("enter_before_reset", {enable_w, enable_s}, {4'b0100, 4'b1000});
    keys = 3'b110;
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_enable", {enable_w, enable_s, active_w, active_s}, 10'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    keys = 3'b111;
    repeat (20) @(negedge clk);
    check("post_reset_w", {sel_w, active_w, enable_w}, 7'b0);
    check("post_reset_s", {sel_s, active_s, enable_s}, 7'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/menu_control.md
MENU_CONTROL -- requirements
Module: menu_control

Interface
REQ-001 Parameter N_FUNC, default 4, number of selectable functions, legal range 2..16.
REQ-002 Parameter SEL_W, default $clog2(N_FUNC), selection index width.
REQ-003 Parameter DEB_CYC, default 1_000_000, debounce stability window in clocks (20 ms at 50 MHz).
REQ-004 Parameter LONG_CYC, default 50_000_000, hold time in clocks that classifies a press as long (1 s).
REQ-005 Parameter BLINK_BIT, default 24, blink-counter bit that drives LED flashing.
REQ-006 Parameter WRAP, default 1; 1 = selection wraps at the ends, 0 = selection saturates.
REQ-007 CLOCK_50  in  1  system clock, 50 MHz; the only clock.
REQ-008 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-009 keys  in  3  raw buttons, active-low (0 = pressed); bit0 = prev/back, bit1 = next, bit2 = enter.
REQ-010 done  in  N_FUNC  per-function exit request from sub-function modules, level, active-high.
REQ-011 enable  out  N_FUNC  one-hot run enable for sub-function modules, registered.
REQ-012 leds  out  N_FUNC  status LEDs, active-high, registered.
REQ-013 sel  out  SEL_W  current selection index, registered.
REQ-014 active  out  1  high while in the ACTIVE state, registered.

Function
REQ-015 Each key SHALL pass a 2-flop synchroniser and a debouncer; the debounced level changes only after DEB_CYC consecutive equal samples.
REQ-016 A short event SHALL be a one-cycle pulse on debounced release when the hold time was < LONG_CYC.
REQ-017 A long event SHALL be a one-cycle pulse issued once, while the key is still held, when the hold time reaches LONG_CYC; the subsequent release SHALL produce no short event.
REQ-018 The hold counter SHALL saturate at LONG_CYC and must not wrap.
REQ-019 The FSM SHALL have two states: SELECT (reset state) and ACTIVE.
REQ-020 In SELECT: key0 short -> sel-1; key1 short -> sel+1; both in the same cycle -> sel unchanged.
REQ-021 In SELECT with WRAP=1: sel-1 at 0 gives N_FUNC-1, and sel+1 at N_FUNC-1 gives 0; with WRAP=0, sel holds at 0 and at N_FUNC-1 respectively.
REQ-022 In SELECT: key2 short (with no key0/key1 short in that cycle) -> ACTIVE on the next edge; enable becomes onehot(sel) and active=1 on that same edge.
REQ-023 In SELECT: long events on any key SHALL be ignored.
REQ-024 In ACTIVE: key0 long or done[sel]=1 -> SELECT on the next edge; enable=0 and active=0 on that edge; sel is retained.
REQ-025 In ACTIVE: all short events, key1/key2 long events, and done bits other than done[sel] SHALL be ignored; sel is frozen.
REQ-026 Priority within one cycle: key0 long > done[sel] > short events.
REQ-027 A 26-bit free-running blink counter SHALL increment every clock and wrap naturally.
REQ-028 leds SHALL equal onehot(sel) gated by counter[BLINK_BIT] in SELECT, and onehot(sel) steady in ACTIVE; registered, 1-cycle latency from state/sel.
REQ-029 enable SHALL be either all-zero or exactly one-hot at all times.

Reset
REQ-030 On rst_n=0, asynchronously: state=SELECT, sel=0, enable=0, active=0, leds=0, blink counter=0, debouncer levels=released, hold counters=0.
REQ-031 A reset during a key hold SHALL discard the press; no event may fire for a press that began before reset release.
REQ-032 A reset in ACTIVE SHALL drop enable to 0 immediately, without waiting for a clock edge.

Structure
REQ-033 A shared package menu_pkg SHALL hold the state enum (SELECT, ACTIVE), the key index constants (KEY_BACK=0, KEY_NEXT=1, KEY_ENTER=2) and the default timing constants.
REQ-034 One sub-module key_event (parameters DEB_CYC and LONG_CYC; outputs short_p and long_p) SHALL be instantiated three times; the FSM, selection logic and LED logic stay in menu_control.

Verification (bench parameters: N_FUNC=4, DEB_CYC=4, LONG_CYC=100, BLINK_BIT=3)
REQ-035 Reset, then key1 pressed for 20 cycles -> one short pulse on release; sel 0->1; enable=0; leds[1] toggles every 8 cycles.
REQ-036 WRAP=1, sel=0, key0 short -> sel=3; WRAP=0, sel=3, key1 short -> sel stays 3.
REQ-037 sel=2, key2 short -> on the next edge enable=4'b0100, active=1, leds=4'b0100 steady; key1 short in ACTIVE -> no change.
REQ-038 ACTIVE on sel=2, key0 held 150 cycles -> long pulse at hold=100, enable=0 and state SELECT before release, no short event on release; done[2]=1 alternatively exits, done[1]=1 ignored.
REQ-039 Glitch: key0 pulsed low for 2 cycles -> no event; same-cycle key0+key1 short -> sel unchanged.
REQ-040 rst_n asserted mid-ACTIVE and mid-hold -> enable=0 asynchronously; after release, no stale event and sel=0.
